pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard / stall / flush controller for a five-stage pipeline.
// Generates the stage-register load enables and bubble flushes. It also
// keeps saturating stall and flush performance counters.
// Build option: define PIPE_CTRL_FWD_EN when the datapath has full
// forwarding. Then only a load-use hazard in EX stalls, for one bubble.
//
// state | meaning
// ------+----------------------------------------------------------
// RUN   | normal issue; hazards, branches and jumps evaluated here
// STALL | remaining data-hazard bubbles being inserted (Wait_Cnt)
// MWAIT | pipe frozen by Mem_Busy; the interrupted state is saved
module pipe_ctrl (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UseRt,
  input  logic [4:0]  E_WReg,
  input  logic        E_RegWr,
  input  logic        E_MemRd,
  input  logic [4:0]  M_WReg,
  input  logic        M_RegWr,
  input  logic        E_BrTaken,
  input  logic        ID_Jump,
  input  logic        Mem_Busy,
  output logic        PC_En,
  output logic        IF_ID_En,
  output logic        ID_Ex_En,
  output logic        Ex_Mem_En,
  output logic        IF_ID_Flush,
  output logic        ID_Ex_Flush,
  output logic [15:0] Stall_Cnt,
  output logic [15:0] Flush_Cnt,
  output logic [1:0]  State
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    MWAIT  = 2'd2,
    UNUSED = 2'd3
  } state_t;

  state_t     state_q, state_d, saved_q, saved_d, eval_st;
  logic [1:0] wait_q, wait_d;
  logic [1:0] bubbles;
  logic       haz_ex;
  logic       stall_inc, flush_inc;

  assign haz_ex = E_RegWr && (E_WReg != 5'd0) &&
                  ((E_WReg == ID_Rs) || (ID_UseRt && (E_WReg == ID_Rt)));

`ifdef PIPE_CTRL_FWD_EN
  // Forwarding covers everything except a load whose data is not yet back.
  assign bubbles = (haz_ex && E_MemRd) ? 2'd1 : 2'd0;
`else
  logic haz_mem;
  logic unused_memrd;
  assign unused_memrd = E_MemRd;
  assign haz_mem = M_RegWr && (M_WReg != 5'd0) &&
                   ((M_WReg == ID_Rs) || (ID_UseRt && (M_WReg == ID_Rt)));
  // Without forwarding the consumer waits until the producer has written back.
  assign bubbles = haz_ex ? 2'd2 : (haz_mem ? 2'd1 : 2'd0);
`endif

  // Next-state, enables and flushes, with reset forcing a safe bubble pattern.
  always_comb begin
    PC_En       = 1'b1;
    IF_ID_En    = 1'b1;
    ID_Ex_En    = 1'b1;
    Ex_Mem_En   = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_Ex_Flush = 1'b0;
    state_d     = RUN;
    saved_d     = saved_q;
    wait_d      = wait_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    // On leaving MWAIT the saved state acts for this cycle. Bad encodings fall back to RUN.
    eval_st = (state_q == MWAIT) ? saved_q : state_q;
    if (eval_st != STALL) eval_st = RUN;

    if (Mem_Busy) begin
      PC_En     = 1'b0;
      IF_ID_En  = 1'b0;
      ID_Ex_En  = 1'b0;
      Ex_Mem_En = 1'b0;
      state_d   = MWAIT;
      saved_d   = eval_st;
    end else if (E_BrTaken) begin
      IF_ID_Flush = 1'b1;
      ID_Ex_Flush = 1'b1;
      wait_d      = 2'd0;
      flush_inc   = 1'b1;
    end else if (eval_st == STALL) begin
      PC_En       = 1'b0;
      IF_ID_En    = 1'b0;
      ID_Ex_Flush = 1'b1;
      stall_inc   = 1'b1;
      wait_d      = (wait_q == 2'd0) ? 2'd0 : wait_q - 2'd1;
      state_d     = (wait_q > 2'd1) ? STALL : RUN;
    end else if (bubbles != 2'd0) begin
      PC_En       = 1'b0;
      IF_ID_En    = 1'b0;
      ID_Ex_Flush = 1'b1;
      stall_inc   = 1'b1;
      wait_d      = bubbles - 2'd1;
      state_d     = (bubbles > 2'd1) ? STALL : RUN;
    end else if (ID_Jump) begin
      IF_ID_Flush = 1'b1;
    end

    if (Rst) begin
      PC_En       = 1'b0;
      IF_ID_En    = 1'b0;
      ID_Ex_En    = 1'b0;
      Ex_Mem_En   = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_Ex_Flush = 1'b1;
    end
  end

  // State, saved state, bubble counter and saturating performance counters.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= RUN;
      saved_q   <= RUN;
      wait_q    <= 2'd0;
      Stall_Cnt <= 16'd0;
      Flush_Cnt <= 16'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      wait_q  <= wait_d;
      if (stall_inc && (Stall_Cnt != 16'hFFFF)) Stall_Cnt <= Stall_Cnt + 16'd1;
      if (flush_inc && (Flush_Cnt != 16'hFFFF)) Flush_Cnt <= Flush_Cnt + 16'd1;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a
// bubble-count reference model. Honours PIPE_CTRL_FWD_EN like the design.
module tb_pipe_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [4:0]  ID_Rs, ID_Rt, E_WReg, M_WReg;
  logic        ID_UseRt, E_RegWr, E_MemRd, M_RegWr, E_BrTaken, ID_Jump, Mem_Busy;
  logic        PC_En, IF_ID_En, ID_Ex_En, Ex_Mem_En, IF_ID_Flush, ID_Ex_Flush;
  logic [15:0] Stall_Cnt, Flush_Cnt;
  logic [1:0]  State;

  pipe_ctrl dut (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
    .E_WReg(E_WReg), .E_RegWr(E_RegWr), .E_MemRd(E_MemRd),
    .M_WReg(M_WReg), .M_RegWr(M_RegWr), .E_BrTaken(E_BrTaken),
    .ID_Jump(ID_Jump), .Mem_Busy(Mem_Busy),
    .PC_En(PC_En), .IF_ID_En(IF_ID_En), .ID_Ex_En(ID_Ex_En), .Ex_Mem_En(Ex_Mem_En),
    .IF_ID_Flush(IF_ID_Flush), .ID_Ex_Flush(ID_Ex_Flush),
    .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt), .State(State)
  );

  always #5 Clk = ~Clk;

  wire [5:0] outs = {PC_En, IF_ID_En, ID_Ex_En, Ex_Mem_En, IF_ID_Flush, ID_Ex_Flush};

  localparam logic [5:0] O_RST = 6'b000011, O_BUSY = 6'b000000, O_BR = 6'b111111;
  localparam logic [5:0] O_STALL = 6'b001101, O_JMP = 6'b111110, O_IDLE = 6'b111100;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining bubbles and counts, not FSM states.
  int m_pend, m_stall, m_flush;
  int n_pend, n_stall, n_flush, n_busy;
  logic [5:0] exp_out;
  logic [1:0] exp_state;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic int model_bubbles();
    bit he, hm;
    he = E_RegWr && E_WReg != 0 && (E_WReg == ID_Rs || (ID_UseRt && E_WReg == ID_Rt));
    hm = M_RegWr && M_WReg != 0 && (M_WReg == ID_Rs || (ID_UseRt && M_WReg == ID_Rt));
`ifdef PIPE_CTRL_FWD_EN
    return (he && E_MemRd) ? 1 : 0;
`else
    return he ? 2 : (hm ? 1 : 0);
`endif
  endfunction

  task automatic model_reset();
    m_pend = 0; m_stall = 0; m_flush = 0; exp_state = 2'd0;
  endtask

  task automatic model_eval();
    int b;
    b = model_bubbles();
    n_pend = m_pend; n_stall = m_stall; n_flush = m_flush; n_busy = 0;
    if (Rst) exp_out = O_RST;
    else if (Mem_Busy) begin exp_out = O_BUSY; n_busy = 1; end
    else if (E_BrTaken) begin exp_out = O_BR; n_pend = 0; n_flush = sat(m_flush + 1); end
    else if (m_pend > 0) begin exp_out = O_STALL; n_pend = m_pend - 1; n_stall = sat(m_stall + 1); end
    else if (b > 0) begin exp_out = O_STALL; n_pend = b - 1; n_stall = sat(m_stall + 1); end
    else if (ID_Jump) exp_out = O_JMP;
    else exp_out = O_IDLE;
  endtask

  task automatic model_clock();
    if (Rst) model_reset();
    else begin
      m_pend = n_pend; m_stall = n_stall; m_flush = n_flush;
      exp_state = (n_busy != 0) ? 2'd2 : ((m_pend > 0) ? 2'd1 : 2'd0);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic usert,
                        input logic [4:0] ew, input logic erw, input logic emr,
                        input logic [4:0] mw, input logic mrw,
                        input logic br, input logic jmp, input logic busy);
    ID_Rs = rs; ID_Rt = rt; ID_UseRt = usert; E_WReg = ew; E_RegWr = erw; E_MemRd = emr;
    M_WReg = mw; M_RegWr = mrw; E_BrTaken = br; ID_Jump = jmp; Mem_Busy = busy;
  endtask

  task automatic set_idle();
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    Rst = 1'b1; #2; Rst = 1'b0; model_reset();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      checks++;
      if (outs !== O_RST) begin errors++; $display("FAIL reset outs %0d: got %b want %b", i, outs, O_RST); end
      checks++;
      if (State !== 2'd0 || Stall_Cnt !== 16'd0 || Flush_Cnt !== 16'd0) begin
        errors++; $display("FAIL reset regs %0d: State=%0d Stall=%0d Flush=%0d want 0/0/0", i, State, Stall_Cnt, Flush_Cnt);
      end
      @(posedge Clk); #1;
    end
    set_idle();
    Rst = 1'b0; model_reset();
  endtask

  // Load-use (forwarding) or ALU-use via Rt (no forwarding) hazard.
  task automatic test_data_hazard();
    do_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef PIPE_CTRL_FWD_EN
      if (i == 0) set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (i == 1) set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      else set_idle();
`else
      if (i < 2) set_in(5'd3, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (i == 2) set_in(5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      else set_idle();
`endif
      #1; model_eval();
      checks++;
      if (outs !== exp_out) begin errors++; $display("FAIL hazard outs %0d: got %b want %b", i, outs, exp_out); end
      @(posedge Clk); model_clock(); #1;
      checks++;
      if (State !== exp_state || Stall_Cnt !== 16'(m_stall)) begin
        errors++; $display("FAIL hazard state %0d: State=%0d Stall=%0d want %0d/%0d", i, State, Stall_Cnt, exp_state, m_stall);
      end
    end
    checks++;
`ifdef PIPE_CTRL_FWD_EN
    if (Stall_Cnt !== 16'd1) begin errors++; $display("FAIL hazard total: Stall_Cnt=%0d want 1", Stall_Cnt); end
`else
    if (Stall_Cnt !== 16'd3) begin errors++; $display("FAIL hazard total: Stall_Cnt=%0d want 3", Stall_Cnt); end
`endif
  endtask

  // Branch in the first stall cycle, then jumps with and without a hazard.
  task automatic test_branch_jump();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        1: set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        2: set_in(5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        3: set_in(5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        default: set_idle();
      endcase
      #1; model_eval();
      checks++;
      if (outs !== exp_out) begin errors++; $display("FAIL brjmp outs %0d: got %b want %b", i, outs, exp_out); end
      if (i == 1) begin
        checks++;
        if (outs !== O_BR) begin errors++; $display("FAIL brjmp branch outs: got %b want %b", outs, O_BR); end
      end
      @(posedge Clk); model_clock(); #1;
      checks++;
      if (State !== exp_state || Flush_Cnt !== 16'(m_flush)) begin
        errors++; $display("FAIL brjmp state %0d: State=%0d Flush=%0d want %0d/%0d", i, State, Flush_Cnt, exp_state, m_flush);
      end
      if (i == 1) begin
        checks++;
        if (State !== 2'd0 || Flush_Cnt !== 16'd1) begin
          errors++; $display("FAIL brjmp abort: State=%0d Flush=%0d want 0/1", State, Flush_Cnt);
        end
      end
    end
  endtask

  // Three busy cycles after the first bubble, then resume the stall.
  task automatic test_mem_busy();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_in(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (i < 4) set_in(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'($urandom), 1'($urandom), 1'b1);
      else set_idle();
      #1; model_eval();
      checks++;
      if (outs !== exp_out) begin errors++; $display("FAIL busy outs %0d: got %b want %b", i, outs, exp_out); end
`ifndef PIPE_CTRL_FWD_EN
      if (i == 4) begin
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL busy resume: got %b want %b", outs, O_STALL); end
      end
`endif
      @(posedge Clk); model_clock(); #1;
      checks++;
      if (State !== exp_state || Stall_Cnt !== 16'(m_stall)) begin
        errors++; $display("FAIL busy state %0d: State=%0d Stall=%0d want %0d/%0d", i, State, Stall_Cnt, exp_state, m_stall);
      end
    end
  endtask

  // Reset pulses mid-STALL (no forwarding) and mid-MWAIT.
  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      if (k == 0) set_in(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      else set_in(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge Clk); #1;
`ifndef PIPE_CTRL_FWD_EN
      checks++;
      if (State !== ((k == 0) ? 2'd1 : 2'd2)) begin errors++; $display("FAIL rstmid pre %0d: State=%0d", k, State); end
`endif
      Rst = 1'b1; #1;
      checks++;
      if (outs !== O_RST || State !== 2'd0 || Stall_Cnt !== 16'd0) begin
        errors++; $display("FAIL rstmid pulse %0d: outs=%b State=%0d Stall=%0d want %b/0/0", k, outs, State, Stall_Cnt, O_RST);
      end
      Rst = 1'b0; model_reset(); set_idle(); #1;
      checks++;
      if (outs !== O_IDLE) begin errors++; $display("FAIL rstmid release %0d: got %b want %b", k, outs, O_IDLE); end
      @(posedge Clk); #1;
      checks++;
      if (State !== 2'd0) begin errors++; $display("FAIL rstmid after %0d: State=%0d want 0", k, State); end
    end
  endtask

  // 70000 hazard cycles saturate Stall_Cnt; register 0 never causes a stall.
  task automatic test_saturation();
    do_reset();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) begin
      #1; model_eval(); @(posedge Clk); model_clock(); #1;
    end
    checks++;
    if (Stall_Cnt !== 16'hFFFF || m_stall != 65535) begin
      errors++; $display("FAIL sat count: got %h want ffff (model %0d)", Stall_Cnt, m_stall);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 2) set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      else set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1; model_eval();
      checks++;
      if (outs !== exp_out) begin errors++; $display("FAIL sat outs %0d: got %b want %b", i, outs, exp_out); end
      @(posedge Clk); model_clock(); #1;
      checks++;
      if (Stall_Cnt !== 16'hFFFF || State !== exp_state) begin
        errors++; $display("FAIL sat hold %0d: Stall=%h State=%0d want ffff/%0d", i, Stall_Cnt, State, exp_state);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 7) == 0));
      #1; model_eval();
      checks++;
      if (outs !== exp_out) begin errors++; $display("FAIL random outs %0d: got %b want %b", i, outs, exp_out); end
      @(posedge Clk); model_clock(); #1;
      checks++;
      if (State !== exp_state || Stall_Cnt !== 16'(m_stall) || Flush_Cnt !== 16'(m_flush)) begin
        errors++; $display("FAIL random state %0d: State=%0d Stall=%0d Flush=%0d want %0d/%0d/%0d",
                           i, State, Stall_Cnt, Flush_Cnt, exp_state, m_stall, m_flush);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    #2;
    test_reset();
    test_data_hazard();
    test_branch_jump();
    test_mem_busy();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
